// File: rtl/wb_macro_mux_pkg.sv
// rtl/wb_macro_mux_pkg.sv - shared state type, address field positions and defaults for wb_macro_mux
package wb_macro_mux_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    localparam int IDX_HI  = 27;
    localparam int IDX_LO  = 24;
    localparam int BASE_HI = 31;
    localparam int BASE_LO = 28;

    function automatic logic [15:0] idx_onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/rst_sync_n.sv
// rtl/rst_sync_n.sv - two-flop reset synchroniser: asserts with rst at once, releases on the 2nd clock edge
module rst_sync_n (
    input  logic clk,
    input  logic rst,
    output logic rst_n_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_n_o = sync_q[1];

endmodule

// File: rtl/wb_macro_mux.sv
// rtl/wb_macro_mux.sv - registered Wishbone fan-out to N_SLAVES user macros with error response.
// Define WB_MUX_TIMEOUT_EN to add the slave-ack timeout counter and irq_o pulse.
module wb_macro_mux
    import wb_macro_mux_pkg::*;
#(
    parameter int          N_SLAVES    = 11,
    parameter logic [3:0]  BASE_NIB    = 4'h3,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [N_SLAVES-1:0]    m_wb_rst_o,
    output logic [N_SLAVES-1:0]    m_wbs_stb_o,
    input  logic [N_SLAVES-1:0]    m_wbs_ack_i,
    input  logic [32*N_SLAVES-1:0] m_wbs_dat_i,
    output logic                   busy_o,
    output logic                   irq_o
);

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [N_SLAVES-1:0] stb_q, stb_d;
    logic [31:0]         dat_q, dat_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                turn_q, turn_d;

    logic        hit, mapped, req_live, sel_ack, macro_rst_n, unused_cfg;
    logic [3:0]  idx;
    logic [15:0] idx_oh;
    logic [31:0] sel_dat;

    rst_sync_n u_rst_sync (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .rst_n_o (macro_rst_n)
    );

    assign m_wb_rst_o = {N_SLAVES{~macro_rst_n}};

    assign idx      = wbs_adr_i[IDX_HI:IDX_LO];
    assign req_live = wbs_cyc_i & wbs_stb_i;
    assign hit      = req_live & (wbs_adr_i[BASE_HI:BASE_LO] == BASE_NIB);
    assign mapped   = ({1'b0, idx} < 5'(N_SLAVES));
    assign idx_oh   = idx_onehot(idx);

    // Only the latched slave's ack and data are visible; other slaves are ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (idx_q == 4'(k)) begin
                sel_ack = m_wbs_ack_i[k];
                sel_dat = m_wbs_dat_i[32*k +: 32];
            end
        end
    end

`ifdef WB_MUX_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;
    logic             expire;

    assign expire     = (cnt_q == CNT_LAST);
    assign irq_o      = irq_q;
    assign unused_cfg = ^wbs_adr_i[23:0];
`else
    assign irq_o      = 1'b0;
    assign unused_cfg = ^{wbs_adr_i[23:0], 32'(TIMEOUT_CYC)};
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stb_d   = stb_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        turn_d  = 1'b0;
`ifdef WB_MUX_TIMEOUT_EN
        cnt_d   = cnt_q;
        irq_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // turn_q blocks a strobe left over from the access just acked
                if (hit && !turn_q) begin
                    if (mapped) begin
                        idx_d   = idx;
                        stb_d   = idx_oh[N_SLAVES-1:0];
                        state_d = S_WAIT;
`ifdef WB_MUX_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        dat_d   = ERR_DATA;
                        ack_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (!req_live) begin
                    stb_d   = '0;
                    state_d = S_IDLE;
                end else if (sel_ack) begin
                    dat_d   = sel_dat;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    state_d = S_RESP;
`ifdef WB_MUX_TIMEOUT_EN
                end else if (expire) begin
                    dat_d   = ERR_DATA;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    irq_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                turn_d  = 1'b1;
            end
            default: begin
                stb_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stb_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            turn_q  <= 1'b0;
`ifdef WB_MUX_TIMEOUT_EN
            cnt_q   <= '0;
            irq_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stb_q   <= stb_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            turn_q  <= turn_d;
`ifdef WB_MUX_TIMEOUT_EN
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
`endif
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign m_wbs_stb_o = stb_q;
    assign busy_o      = busy_q;

endmodule
